// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 8-bit CPU datapath.
// Optional single-step mode is enabled by defining CTRL_STEP_EN.
module cpu_ctrl_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [7:0]       instr,
  input  logic             mem_ready,
`ifdef CTRL_STEP_EN
  input  logic             step,
`endif
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             alusrc,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             mem_read,
  output logic             mem_write,
  output logic             busy,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd6,
    PAUSE  = 3'd7
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t           state_r;
  state_t           state_n_s;
  state_t           boundary_s;
  logic [1:0]       op_q_r;
  logic [1:0]       op_n_s;
  logic [7:0]       tcnt_r;
  logic [7:0]       tcnt_n_s;
  logic             retire_s;
  logic             step_rise_s;
  logic             ir_write_r;
  logic             alusrc_r;
  logic             reg_write_r;
  logic             mem_to_reg_r;
  logic             mem_read_r;
  logic             mem_write_r;
  logic             busy_r;
  logic             err_r;
  logic [CNT_W-1:0] retired_r;
  logic             pc_write_s;
  logic             pc_src_s;
  logic             instr_unused_s;

  assign instr_unused_s = ^instr[5:0];

`ifdef CTRL_STEP_EN
  logic step_q_r;
  assign step_rise_s = step & ~step_q_r;
  assign boundary_s  = stop ? IDLE : PAUSE;
`else
  assign step_rise_s = 1'b0;
  assign boundary_s  = stop ? IDLE : FETCH;
`endif

  // Next-state, opcode capture, timeout count and retire decision.
  always_comb begin
    state_n_s = state_r;
    op_n_s    = op_q_r;
    tcnt_n_s  = 8'd0;
    retire_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n_s = FETCH;
        end else begin
          state_n_s = IDLE;
        end
      end
      FETCH: state_n_s = DECODE;
      DECODE: begin
        op_n_s = instr[7:6];
        if (instr[7:6] == OP_J) begin
          retire_s  = 1'b1;
          state_n_s = boundary_s;
        end else begin
          state_n_s = EXEC;
        end
      end
      EXEC: begin
        if (op_q_r == OP_ADD) begin
          state_n_s = WB;
        end else begin
          state_n_s = MEM;
        end
      end
      MEM: begin
        if (mem_ready) begin
          if (op_q_r == OP_LW) begin
            state_n_s = WB;
          end else begin
            retire_s  = 1'b1;
            state_n_s = boundary_s;
          end
        end else if (tcnt_r == TMO_LAST) begin
          state_n_s = ERR;
        end else begin
          tcnt_n_s  = tcnt_r + 8'd1;
          state_n_s = MEM;
        end
      end
      WB: begin
        retire_s  = 1'b1;
        state_n_s = boundary_s;
      end
      ERR: state_n_s = ERR;
      PAUSE: begin
        if (step_rise_s) begin
          state_n_s = FETCH;
        end else begin
          state_n_s = PAUSE;
        end
      end
      default: state_n_s = IDLE;
    endcase
  end

  // PC controls depend on the live opcode in DECODE and on mem_ready in MEM.
  always_comb begin
    pc_write_s = 1'b0;
    pc_src_s   = 1'b0;
    case (state_r)
      DECODE: begin
        if (instr[7:6] == OP_J) begin
          pc_write_s = 1'b1;
          pc_src_s   = 1'b1;
        end else begin
          pc_write_s = 1'b0;
        end
      end
      MEM: begin
        if (mem_ready && (op_q_r == OP_SW)) begin
          pc_write_s = 1'b1;
        end else begin
          pc_write_s = 1'b0;
        end
      end
      WB:      pc_write_s = 1'b1;
      default: pc_write_s = 1'b0;
    endcase
  end

  // State register plus outputs registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      op_q_r       <= 2'b00;
      tcnt_r       <= 8'd0;
      retired_r    <= '0;
      ir_write_r   <= 1'b0;
      alusrc_r     <= 1'b0;
      reg_write_r  <= 1'b0;
      mem_to_reg_r <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
`ifdef CTRL_STEP_EN
      step_q_r     <= 1'b0;
`endif
    end else begin
      state_r      <= state_n_s;
      op_q_r       <= op_n_s;
      tcnt_r       <= tcnt_n_s;
      if (retire_s) begin
        retired_r  <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      ir_write_r   <= (state_n_s == FETCH);
      alusrc_r     <= (state_n_s == EXEC) && ((op_n_s == OP_LW) || (op_n_s == OP_SW));
      reg_write_r  <= (state_n_s == WB);
      mem_to_reg_r <= (state_n_s == WB) && (op_n_s == OP_LW);
      mem_read_r   <= (state_n_s == MEM) && (op_n_s == OP_LW);
      mem_write_r  <= (state_n_s == MEM) && (op_n_s == OP_SW);
      busy_r       <= (state_n_s != IDLE) && (state_n_s != ERR);
      err_r        <= (state_n_s == ERR);
`ifdef CTRL_STEP_EN
      step_q_r     <= step;
`endif
    end
  end

  assign pc_write   = pc_write_s;
  assign pc_src     = pc_src_s;
  assign ir_write   = ir_write_r;
  assign alusrc     = alusrc_r;
  assign reg_write  = reg_write_r;
  assign mem_to_reg = mem_to_reg_r;
  assign mem_read   = mem_read_r;
  assign mem_write  = mem_write_r;
  assign busy       = busy_r;
  assign err        = err_r;
  assign state      = state_r;
  assign retired    = retired_r;

endmodule
